spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 215 +++++++++++++++++++++
 tb/tb_spi_master.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master
//  Description : Single-byte SPI master, mode 0 (sck idles low, data sampled
//                on the rising edge and launched on the falling edge). Bytes
//                are taken through a valid/ready handshake; a byte offered at
//                the end of the current byte is chained with no sck gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master #(
    parameter int HALF_PERIOD = 2,   // clk cycles per sck half-period, 1..255
    parameter int LSB_FIRST   = 0    // 0: MSB first, 1: LSB first
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       ssel_
);

    // Terminal value of the half-period counter.
    localparam logic [7:0] c_hp_last = 8'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TRAIL = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [7:0] r_hcnt;        // clk cycles within the current sck half-period
    logic [2:0] r_bit;         // bit index within the current byte
    logic       r_sck;
    logic       r_ssel;
    logic       r_busy;
    logic [7:0] r_tx;          // transmit shifter; its leading bit drives mosi
    logic [7:0] r_rx;          // receive shifter
    logic [7:0] r_rx_data;
    logic       r_rx_valid;

    logic       w_tick;        // half-period boundary reached this cycle
    logic       w_rise;        // sck goes high at the end of this cycle
    logic       w_fall;        // sck goes low at the end of this cycle
    logic       w_last;        // this fall completes the 8th bit
    logic       w_trail_end;   // slave-select hold time after the byte elapsed
    logic       w_accept;      // handshake completes this cycle
    logic [7:0] w_tx_shifted;
    logic [7:0] w_rx_shifted;

    // Bit ordering is fixed at elaboration: pick shift direction and the
    // shifter bit that is presented on mosi.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_tx_shifted = {1'b0, r_tx[7:1]};
            assign w_rx_shifted = {miso, r_rx[7:1]};
            assign mosi         = r_tx[0];
        end else begin : g_msb_first
            assign w_tx_shifted = {r_tx[6:0], 1'b0};
            assign w_rx_shifted = {r_rx[6:0], miso};
            assign mosi         = r_tx[7];
        end
    endgenerate

    // Next-state decode, sck edge strobes and the ready handshake.
    always_comb begin
        w_state_next = r_state;
        w_tick       = (r_hcnt == c_hp_last);
        w_rise       = 1'b0;
        w_fall       = 1'b0;
        w_last       = 1'b0;
        w_trail_end  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tx_valid) begin
                    w_state_next = ST_LEAD;
                end
            end
            ST_LEAD: begin
                // First half-period with sck low before the first rising edge.
                if (w_tick) begin
                    w_rise       = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    if (r_sck) begin
                        w_fall = 1'b1;
                        if (r_bit == 3'd7) begin
                            w_last       = 1'b1;
                            // A byte offered now is chained straight on.
                            w_state_next = tx_valid ? ST_LEAD : ST_TRAIL;
                        end
                    end else begin
                        w_rise = 1'b1;
                    end
                end
            end
            ST_TRAIL: begin
                if (w_tick) begin
                    w_trail_end  = 1'b1;
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // Held low during reset so nothing upstream sees a phantom slot.
        tx_ready = rst_ && ((r_state == ST_IDLE) || w_last);
        w_accept = tx_valid && tx_ready;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Half-period and bit counters; the half-period counter wraps at its
    // terminal value and is held at zero while idle.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_hcnt <= 8'd0;
            r_bit  <= 3'd0;
        end else begin
            if ((r_state == ST_IDLE) || w_tick) begin
                r_hcnt <= 8'd0;
            end else begin
                r_hcnt <= r_hcnt + 8'd1;
            end
            if (w_accept) begin
                r_bit <= 3'd0;
            end else if (w_fall && !w_last) begin
                r_bit <= r_bit + 3'd1;
            end
        end
    end

    // Serial interface: sck, slave select, busy and the transmit shifter.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_sck  <= 1'b0;
            r_ssel <= 1'b1;
            r_busy <= 1'b0;
            r_tx   <= 8'h00;
        end else begin
            r_busy <= (w_state_next != ST_IDLE);
            if (w_rise) begin
                r_sck <= 1'b1;
            end else if (w_fall) begin
                r_sck <= 1'b0;
            end
            if (w_trail_end) begin
                r_ssel <= 1'b1;
            end
            // mosi only moves on a falling edge or when a byte is loaded;
            // it parks at 0 once the byte is finished.
            if (w_accept) begin
                r_ssel <= 1'b0;
                r_tx   <= tx_data;
            end else if (w_fall) begin
                r_tx   <= w_last ? 8'h00 : w_tx_shifted;
            end
        end
    end

    // Receive path: sample miso as sck rises, publish the byte on the 8th fall.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_rx       <= 8'h00;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_rise) begin
                r_rx <= w_rx_shifted;
            end
            if (w_last) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= r_rx;
            end
            if (w_accept) begin
                r_rx <= 8'h00;
            end
        end
    end

    assign sck      = r_sck;
    assign ssel_    = r_ssel;
    assign busy     = r_busy;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master
//  Description : Self-checking bench for spi_master. Two instances are built,
//                one MSB-first with a 2-cycle half period and one LSB-first
//                with a 1-cycle half period; a select line routes stimulus
//                and observation to one of them at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst_;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       sel;          // 0: instance a, 1: instance b
    logic       loop;         // miso looped back from mosi
    logic       miso_drv;     // slave model output

    logic       a_tx_ready, a_rx_valid, a_busy, a_sck, a_mosi, a_ssel_, a_miso;
    logic [7:0] a_rx_data;
    logic       b_tx_ready, b_rx_valid, b_busy, b_sck, b_mosi, b_ssel_, b_miso;
    logic [7:0] b_rx_data;

    logic       m_tx_ready, m_rx_valid, m_busy, m_sck, m_mosi, m_ssel_;
    logic [7:0] m_rx_data;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign a_miso = loop ? a_mosi : miso_drv;
    assign b_miso = loop ? b_mosi : miso_drv;

    spi_master #(.HALF_PERIOD(2), .LSB_FIRST(0)) u_a (
        .clk      (clk),
        .rst_     (rst_),
        .tx_data  (tx_data),
        .tx_valid (tx_valid && !sel),
        .tx_ready (a_tx_ready),
        .rx_data  (a_rx_data),
        .rx_valid (a_rx_valid),
        .busy     (a_busy),
        .sck      (a_sck),
        .mosi     (a_mosi),
        .miso     (a_miso),
        .ssel_    (a_ssel_)
    );

    spi_master #(.HALF_PERIOD(1), .LSB_FIRST(1)) u_b (
        .clk      (clk),
        .rst_     (rst_),
        .tx_data  (tx_data),
        .tx_valid (tx_valid && sel),
        .tx_ready (b_tx_ready),
        .rx_data  (b_rx_data),
        .rx_valid (b_rx_valid),
        .busy     (b_busy),
        .sck      (b_sck),
        .mosi     (b_mosi),
        .miso     (b_miso),
        .ssel_    (b_ssel_)
    );

    assign m_tx_ready = sel ? b_tx_ready : a_tx_ready;
    assign m_rx_valid = sel ? b_rx_valid : a_rx_valid;
    assign m_rx_data  = sel ? b_rx_data  : a_rx_data;
    assign m_busy     = sel ? b_busy     : a_busy;
    assign m_sck      = sel ? b_sck      : a_sck;
    assign m_mosi     = sel ? b_mosi     : a_mosi;
    assign m_ssel_    = sel ? b_ssel_    : a_ssel_;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bit i (in wire order) of a byte.
    function automatic logic bit_of(input logic [7:0] b, input int i, input bit lsb);
        return lsb ? b[i] : b[7-i];
    endfunction

    // Send the bytes of txq back to back (tx_valid held high) while a slave
    // model returns the bytes of slq, then check everything the protocol
    // promises: accept cycles, mosi bits, rx timing and data, ssel_ release,
    // return to idle. pulse_at > 0 offers 8'h77 for one cycle at that cycle.
    task automatic run_frames(input string nm, input int hp, input bit lsb,
                              input bq_t txq, input bq_t slq, input bit lp,
                              input int pulse_at);
        int         n;
        int         t;
        int         k_acc;
        int         n_rx;
        int         n_rise;
        int         n_fall;
        int         t_ssel_hi;
        bit         done;
        bit         acc_now;
        logic       prev_sck;
        logic [7:0] exp_last;
        n         = txq.size();
        t         = 0;
        k_acc     = 0;
        n_rx      = 0;
        n_rise    = 0;
        n_fall    = 0;
        t_ssel_hi = -1;
        done      = 1'b0;
        loop      = lp;
        miso_drv  = bit_of(slq[0], 0, lsb);
        tx_data   = txq[0];
        tx_valid  = 1'b1;
        exp_last  = lp ? txq[n-1] : slq[n-1];
        chk({nm, "_ready_idle"}, 32'(m_tx_ready), 1);
        for (int c = 0; c < 40 * hp * n + 100; c++) begin
            acc_now = tx_valid && m_tx_ready;
            if (acc_now) begin
                chk({nm, "_accept_cycle"}, t, (k_acc < n) ? 16 * hp * k_acc : -1);
            end
            prev_sck = m_sck;
            step();
            t++;
            if (acc_now) begin
                k_acc++;
                if (k_acc < n) begin
                    tx_data = txq[k_acc];
                end else begin
                    tx_valid = 1'b0;
                    tx_data  = 8'($urandom);
                end
            end
            if (t == pulse_at) begin
                chk({nm, "_ready_in_shift"}, 32'(m_tx_ready), 0);
                tx_valid = 1'b1;
                tx_data  = 8'h77;
            end else if (pulse_at > 0 && t == pulse_at + 1) begin
                tx_valid = 1'b0;
            end
            if (t == 1) begin
                chk({nm, "_lead_ssel"}, 32'(m_ssel_), 0);
                chk({nm, "_lead_sck"}, 32'(m_sck), 0);
                chk({nm, "_lead_mosi"}, 32'(m_mosi), 32'(bit_of(txq[0], 0, lsb)));
            end
            if (!prev_sck && m_sck) begin
                if (n_rise < 8 * n) begin
                    chk({nm, "_mosi_bit"}, 32'(m_mosi), 32'(bit_of(txq[n_rise / 8], n_rise % 8, lsb)));
                end
                chk({nm, "_ssel_at_rise"}, 32'(m_ssel_), 0);
                n_rise++;
            end
            if (prev_sck && !m_sck) begin
                n_fall++;
                miso_drv = (n_fall < 8 * n) ? bit_of(slq[n_fall / 8], n_fall % 8, lsb) : 1'b0;
            end
            if (m_rx_valid) begin
                if (n_rx < n) begin
                    chk({nm, "_rx_cycle"}, t, 16 * hp * (n_rx + 1) + 1);
                    chk({nm, "_rx_data"}, 32'(m_rx_data), 32'(lp ? txq[n_rx] : slq[n_rx]));
                end
                n_rx++;
            end
            if (m_ssel_) begin
                chk({nm, "_mosi_deselected"}, 32'(m_mosi), 0);
                if (t_ssel_hi < 0) t_ssel_hi = t;
            end
            if (!m_busy) begin
                done = 1'b1;
                break;
            end
        end
        chk({nm, "_finished"}, 32'(done), 1);
        chk({nm, "_idle_cycle"}, t, 16 * hp * n + 1 + 2 * hp);
        chk({nm, "_ssel_release"}, t_ssel_hi, 16 * hp * n + 1 + hp);
        chk({nm, "_rise_count"}, n_rise, 8 * n);
        chk({nm, "_rx_count"}, n_rx, n);
        chk({nm, "_accept_count"}, k_acc, n);
        chk({nm, "_ready_after"}, 32'(m_tx_ready), 1);
        repeat (3) step();
        chk({nm, "_rx_hold"}, 32'(m_rx_data), 32'(exp_last));
        chk({nm, "_sck_idle"}, 32'(m_sck), 0);
        chk({nm, "_ssel_idle"}, 32'(m_ssel_), 1);
    endtask

    initial begin
        bq_t        tq;
        bq_t        sq;
        int         rises;
        int         pulses;
        logic       ps;
        rst_     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        sel      = 1'b0;
        loop     = 1'b0;
        miso_drv = 1'b0;

        // Reset state of both instances.
        repeat (3) step();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_sck", 32'(m_sck), 0);
            chk("rst_ssel", 32'(m_ssel_), 1);
            chk("rst_mosi", 32'(m_mosi), 0);
            chk("rst_rx_valid", 32'(m_rx_valid), 0);
            chk("rst_rx_data", 32'(m_rx_data), 0);
            chk("rst_busy", 32'(m_busy), 0);
            chk("rst_tx_ready", 32'(m_tx_ready), 0);
        end
        sel  = 1'b0;
        rst_ = 1'b1;
        #1;
        chk("release_ready", 32'(m_tx_ready), 1);
        step();

        // Loopback of 8'hF0.
        tq.delete(); sq.delete();
        tq.push_back(8'hF0); sq.push_back(8'h00);
        run_frames("loop_f0", 2, 1'b0, tq, sq, 1'b1, -1);

        // miso tied high while sending zeros.
        tq.delete(); sq.delete();
        tq.push_back(8'h00); sq.push_back(8'hFF);
        run_frames("miso_high", 2, 1'b0, tq, sq, 1'b0, -1);

        // Two chained bytes with tx_valid held high.
        tq.delete(); sq.delete();
        tq.push_back(8'hA5); tq.push_back(8'h3C);
        sq.push_back(8'h00); sq.push_back(8'h00);
        run_frames("chain", 2, 1'b0, tq, sq, 1'b1, -1);

        // Randomised frames on the MSB-first instance.
        for (int r = 0; r < 5; r++) begin
            int nb;
            nb = int'($urandom_range(1, 3));
            tq.delete(); sq.delete();
            for (int k = 0; k < nb; k++) begin
                tq.push_back(8'($urandom));
                sq.push_back(8'($urandom));
            end
            run_frames("rand_a", 2, 1'b0, tq, sq, 1'($urandom_range(0, 1)), -1);
        end

        // Reset in the middle of a byte.
        loop     = 1'b1;
        tx_data  = 8'hE0;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rises    = 0;
        for (int c = 0; c < 200 && rises < 3; c++) begin
            ps = m_sck;
            step();
            if (!ps && m_sck) rises++;
        end
        chk("abort_third_rise", rises, 3);
        chk("abort_mosi_before", 32'(m_mosi), 1);
        #2;
        rst_ = 1'b0;
        #1;
        chk("abort_ssel", 32'(m_ssel_), 1);
        chk("abort_sck", 32'(m_sck), 0);
        chk("abort_mosi", 32'(m_mosi), 0);
        chk("abort_busy", 32'(m_busy), 0);
        chk("abort_ready", 32'(m_tx_ready), 0);
        step();
        step();
        rst_ = 1'b1;
        #1;
        chk("abort_release_ready", 32'(m_tx_ready), 1);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (m_rx_valid) pulses++;
        end
        chk("abort_no_rx", pulses, 0);
        chk("abort_idle", 32'(m_busy), 0);
        tq.delete(); sq.delete();
        tq.push_back(8'h5A); sq.push_back(8'h00);
        run_frames("after_abort", 2, 1'b0, tq, sq, 1'b1, -1);

        // A byte offered while busy is dropped.
        tq.delete(); sq.delete();
        tq.push_back(8'($urandom)); sq.push_back(8'($urandom));
        run_frames("ignored", 2, 1'b0, tq, sq, 1'b0, 10);

        // LSB-first instance with a 1-cycle half period.
        sel = 1'b1;
        step();
        tq.delete(); sq.delete();
        tq.push_back(8'h01); sq.push_back(8'h00);
        run_frames("lsb_01", 1, 1'b1, tq, sq, 1'b1, -1);
        for (int r = 0; r < 3; r++) begin
            int nb;
            nb = int'($urandom_range(1, 3));
            tq.delete(); sq.delete();
            for (int k = 0; k < nb; k++) begin
                tq.push_back(8'($urandom));
                sq.push_back(8'($urandom));
            end
            run_frames("rand_b", 1, 1'b1, tq, sq, 1'($urandom_range(0, 1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute time bound on the whole run.
    initial begin
        #1000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
